// File: rtl/serial_magnitude_comparator.sv
// serial_magnitude_comparator: unsigned A/B compare, one bit per clock, MSB first.
// Build macro CMP_EARLY_EXIT_EN ends the scan at the first differing bit.
module serial_magnitude_comparator #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             less_than,
  output logic             equal_to,
  output logic             greater_than,
  output logic             busy
);

  localparam int unsigned      IDX_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             lt_q, lt_d;
  logic             eq_q, eq_d;
  logic             gt_q, gt_d;
  logic             ready_q, valid_q, busy_q;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic             a_bit, b_bit;
`ifndef CMP_EARLY_EXIT_EN
  logic             seen_q, seen_d;
  logic             seen_gt_q, seen_gt_d;
`endif

  // Shift rather than index so WIDTH=1 needs no zero-width select.
  assign a_sh  = a_q >> idx_q;
  assign b_sh  = b_q >> idx_q;
  assign a_bit = a_sh[0];
  assign b_bit = b_sh[0];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
`ifndef CMP_EARLY_EXIT_EN
    seen_d    = seen_q;
    seen_gt_d = seen_gt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start_valid && ready_q) begin
          a_d     = a;
          b_d     = b;
          idx_d   = IDX_TOP;
          lt_d    = 1'b0;
          eq_d    = 1'b0;
          gt_d    = 1'b0;
`ifndef CMP_EARLY_EXIT_EN
          seen_d    = 1'b0;
          seen_gt_d = 1'b0;
`endif
          state_d = SCAN;
        end
      end
      SCAN: begin
`ifdef CMP_EARLY_EXIT_EN
        if (a_bit != b_bit) begin
          lt_d    = b_bit;
          gt_d    = a_bit;
          eq_d    = 1'b0;
          state_d = DONE;
        end else if (idx_q == '0) begin
          eq_d    = 1'b1;
          state_d = DONE;
        end else begin
          idx_d = idx_q - IDX_ONE;
        end
`else
        // First difference is sticky; lower bits are scanned but cannot override it.
        if (!seen_q && (a_bit != b_bit)) begin
          seen_d    = 1'b1;
          seen_gt_d = a_bit;
        end
        if (idx_q == '0) begin
          eq_d    = !seen_d;
          gt_d    = seen_d && seen_gt_d;
          lt_d    = seen_d && !seen_gt_d;
          state_d = DONE;
        end else begin
          idx_d = idx_q - IDX_ONE;
        end
`endif
      end
      DONE: begin
        if (valid_q && result_ready) begin
          lt_d    = 1'b0;
          eq_d    = 1'b0;
          gt_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        lt_d    = 1'b0;
        eq_d    = 1'b0;
        gt_d    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Status outputs are registered from the next state so nothing is combinational.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      idx_q     <= '0;
      lt_q      <= 1'b0;
      eq_q      <= 1'b0;
      gt_q      <= 1'b0;
      ready_q   <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
`ifndef CMP_EARLY_EXIT_EN
      seen_q    <= 1'b0;
      seen_gt_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      idx_q     <= idx_d;
      lt_q      <= lt_d;
      eq_q      <= eq_d;
      gt_q      <= gt_d;
      ready_q   <= (state_d == IDLE);
      valid_q   <= (state_d == DONE);
      busy_q    <= (state_d == SCAN);
`ifndef CMP_EARLY_EXIT_EN
      seen_q    <= seen_d;
      seen_gt_q <= seen_gt_d;
`endif
    end
  end

  assign start_ready  = ready_q;
  assign result_valid = valid_q;
  assign busy         = busy_q;
  assign less_than    = lt_q;
  assign equal_to     = eq_q;
  assign greater_than = gt_q;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Randomized bench for serial_magnitude_comparator (WIDTH=8 plus a WIDTH=1 instance)
// with a cycle-level latency/result model derived from operand arithmetic.
module tb_serial_magnitude_comparator;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start_valid = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       result_ready = 1'b0;
  logic       start_ready, result_valid, less_than, equal_to, greater_than, busy;

  logic       w1_start_valid = 1'b0;
  logic [0:0] w1_a = '0;
  logic [0:0] w1_b = '0;
  logic       w1_result_ready = 1'b0;
  logic       w1_start_ready, w1_result_valid, w1_lt, w1_eq, w1_gt, w1_busy;

  int tests = 0;
  int fails = 0;
  logic chk_on = 1'b0;

  always #5 clk = ~clk;

  serial_magnitude_comparator #(.WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .start_valid(start_valid), .start_ready(start_ready),
    .a(a), .b(b), .result_valid(result_valid), .result_ready(result_ready),
    .less_than(less_than), .equal_to(equal_to), .greater_than(greater_than), .busy(busy)
  );

  serial_magnitude_comparator #(.WIDTH(1)) dut_w1 (
    .clk(clk), .reset_n(reset_n), .start_valid(w1_start_valid), .start_ready(w1_start_ready),
    .a(w1_a), .b(w1_b), .result_valid(w1_result_valid), .result_ready(w1_result_ready),
    .less_than(w1_lt), .equal_to(w1_eq), .greater_than(w1_gt), .busy(w1_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Cycles from accept edge to result_valid, from the operands alone.
  function automatic int exp_lat(input logic [7:0] x, input logic [7:0] y);
`ifdef CMP_EARLY_EXIT_EN
    logic [7:0] d;
    d = x ^ y;
    for (int i = 7; i >= 0; i--)
      if (d[i]) return 8 - i;
    return 8;
`else
    return 8 + 0 * int'(x ^ y);
`endif
  endfunction

  function automatic logic [2:0] exp_flags(input logic [7:0] x, input logic [7:0] y);
    return {x < y, x == y, x > y};
  endfunction

  // Handshake-level model: ready / busy countdown / held result.
  logic       m_ready, m_busy, m_valid;
  logic [2:0] m_flags, m_pend;
  int         m_left;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_ready <= 1'b0; m_busy <= 1'b0; m_valid <= 1'b0;
      m_flags <= '0;   m_pend <= '0;   m_left  <= 0;
    end else if (m_ready) begin
      if (start_valid) begin
        m_ready <= 1'b0;
        m_busy  <= 1'b1;
        m_left  <= exp_lat(a, b);
        m_pend  <= exp_flags(a, b);
      end
    end else if (m_busy) begin
      if (m_left == 1) begin
        m_busy  <= 1'b0;
        m_valid <= 1'b1;
        m_flags <= m_pend;
      end else begin
        m_left <= m_left - 1;
      end
    end else if (m_valid) begin
      if (result_ready) begin
        m_valid <= 1'b0;
        m_flags <= '0;
        m_ready <= 1'b1;
      end
    end else begin
      m_ready <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_on)
      check("cycle {ready,busy,valid,lt,eq,gt}",
            32'({start_ready, busy, result_valid, less_than, equal_to, greater_than}),
            32'({m_ready, m_busy, m_valid, m_flags}));
  end

  task automatic accept_job(input logic [7:0] x, input logic [7:0] y, output int waited);
    waited = 0;
    while (!start_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) check("accept timeout", 32'(waited), 32'd0);
    start_valid = 1'b1;
    a = x;
    b = y;
    @(negedge clk);
    start_valid = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!result_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 100) check("result timeout", 32'(lat), 32'd0);
  endtask

  task automatic finish_job();
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
  endtask

  task automatic directed(input string name, input logic [7:0] x, input logic [7:0] y,
                          input int lat_exp, input logic [2:0] fl_exp);
    int w, lat;
    accept_job(x, y, w);
    wait_result(lat);
    check({name, " latency"}, 32'(lat), 32'(lat_exp));
    check({name, " flags"}, 32'({less_than, equal_to, greater_than}), 32'(fl_exp));
    finish_job();
  endtask

  task automatic w1_job(input logic x, input logic y, input logic [2:0] fl_exp);
    int lat, g;
    g = 0;
    while (!w1_start_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (g >= 20) check("w1 accept timeout", 32'(g), 32'd0);
    w1_start_valid = 1'b1;
    w1_a = x;
    w1_b = y;
    @(negedge clk);
    w1_start_valid = 1'b0;
    check("w1 busy after accept", 32'(w1_busy), 32'd1);
    lat = 0;
    while (!w1_result_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("w1 latency", 32'(lat), 32'd1);
    check("w1 flags", 32'({w1_lt, w1_eq, w1_gt}), 32'(fl_exp));
    w1_result_ready = 1'b1;
    @(negedge clk);
    w1_result_ready = 1'b0;
    check("w1 idle after handshake", 32'({w1_start_ready, w1_result_valid}), 32'b10);
  endtask

  initial begin
    int w, lat, early;
    logic [2:0] held;
    logic [7:0] x, y;
`ifdef CMP_EARLY_EXIT_EN
    early = 1;
`else
    early = 0;
`endif

    // Pin the model against hand-computed values.
    check("model lat A5/25", 32'(exp_lat(8'hA5, 8'h25)), early ? 32'd1 : 32'd8);
    check("model lat 3C/3D", 32'(exp_lat(8'h3C, 8'h3D)), 32'd8);
    check("model lat 01/02", 32'(exp_lat(8'h01, 8'h02)), early ? 32'd7 : 32'd8);
    check("model flags 00/FF", 32'(exp_flags(8'h00, 8'hFF)), 32'b100);
    check("model flags 7E/7E", 32'(exp_flags(8'h7E, 8'h7E)), 32'b010);

    repeat (2) @(negedge clk);
    check("reset outputs", 32'({start_ready, busy, result_valid, less_than, equal_to, greater_than}), 32'd0);
    chk_on = 1'b1;
    reset_n = 1'b1;
    @(negedge clk);
    check("start_ready after reset", 32'(start_ready), 32'd1);

    directed("A5>25", 8'hA5, 8'h25, early ? 1 : 8, 3'b001);
    directed("3C<3D", 8'h3C, 8'h3D, 8, 3'b100);

    // Equal job, then back-to-back accept one cycle after the handshake.
    accept_job(8'h7E, 8'h7E, w);
    wait_result(lat);
    check("7E==7E latency", 32'(lat), 32'd8);
    check("7E==7E flags", 32'({less_than, equal_to, greater_than}), 32'b010);
    finish_job();
    check("ready right after handshake", 32'(start_ready), 32'd1);
    accept_job(8'h00, 8'hFF, w);
    check("second accept wait", 32'(w), 32'd0);
    wait_result(lat);
    check("00<FF latency", 32'(lat), early ? 32'd1 : 32'd8);
    check("00<FF flags", 32'({less_than, equal_to, greater_than}), 32'b100);
    finish_job();

    // Backpressure with a competing request pending.
    accept_job(8'h12, 8'h34, w);
    wait_result(lat);
    held = {less_than, equal_to, greater_than};
    check("bp flags", 32'(held), 32'b100);
    start_valid = 1'b1;
    a = 8'hFF;
    b = 8'h00;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp held flags", 32'({less_than, equal_to, greater_than}), 32'(held));
      check("bp ready low", 32'({start_ready, result_valid}), 32'b01);
    end
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    check("bp release", 32'({start_ready, result_valid}), 32'b10);
    @(negedge clk);
    start_valid = 1'b0;
    wait_result(lat);
    check("bp next job flags", 32'({less_than, equal_to, greater_than}), 32'b001);
    finish_job();

    // Reset during SCAN (idx 4 in the full-scan build).
    accept_job(8'h80, 8'h7F, w);
    repeat (3) @(negedge clk);
    #1 reset_n = 1'b0;
    #1 check("mid-scan reset outputs",
             32'({start_ready, busy, result_valid, less_than, equal_to, greater_than}), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("ready after mid-scan reset", 32'(start_ready), 32'd1);
    directed("01<02 after reset", 8'h01, 8'h02, early ? 7 : 8, 3'b100);

    // WIDTH=1 corner cases.
    w1_job(1'b1, 1'b0, 3'b001);
    w1_job(1'b1, 1'b1, 3'b010);
    w1_job(1'b0, 1'b1, 3'b100);

    // Randomized jobs with random consumer stalls.
    for (int n = 0; n < 60; n++) begin
      x = 8'($urandom);
      case ($urandom_range(0, 3))
        0: y = x;
        1: y = x ^ (8'h01 << $urandom_range(0, 7));
        default: y = 8'($urandom);
      endcase
      accept_job(x, y, w);
      wait_result(lat);
      check("rand latency", 32'(lat), 32'(exp_lat(x, y)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      finish_job();
    end

    repeat (2) @(negedge clk);
    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_magnitude_comparator.md
# serial_magnitude_comparator

Sequential unsigned magnitude comparator that resolves two WIDTH-bit operands one bit per clock, MSB first. It evaluates a single bit position per cycle, so only one bit-compare is active at a time, which suits power-gated designs. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.

## Interface
- WIDTH, 8: operand width in bits; legal range is 1 to 64.
- clk  in  1: single clock; all state changes on its rising edge.
- reset_n  in  1: asynchronous, active-low reset.
- start_valid  in  1: producer has operands on a/b.
- start_ready  out  1: block can accept operands; high only in IDLE.
- a  in  WIDTH: operand A, unsigned.
- b  in  WIDTH: operand B, unsigned.
- result_valid  out  1: result flags are valid.
- result_ready  in  1: consumer accepts the result.
- less_than  out  1: A < B.
- equal_to  out  1: A == B.
- greater_than  out  1: A > B.
- busy  out  1: high in SCAN.

## Operation
- Internal state: a_q, b_q (WIDTH each), idx (sized to hold 0 to WIDTH-1), and the result flags.
- IDLE:
  - start_ready=1.
  - On start_valid && start_ready, latch a→a_q and b→b_q, set idx=WIDTH-1, go to SCAN.
- SCAN: each cycle, compare a_q[idx] with b_q[idx].
  - Bits differ: set less_than=b_q[idx], greater_than=a_q[idx], equal_to=0, then go to DONE (early-exit build).
  - Bits equal and idx==0: set equal_to=1, go to DONE.
  - Otherwise: decrement idx.
- DONE:
  - result_valid=1 and the flags are held stable.
  - On result_valid && result_ready, clear the flags and go to IDLE.
- Exactly one flag is high while result_valid=1. All three flags are 0 whenever result_valid=0.
- Operand inputs a/b are ignored outside the accept handshake. start_valid is ignored outside IDLE.
- WIDTH=1: SCAN lasts exactly one cycle.
- Reset (any state, including mid-SCAN or DONE):
  - Outputs immediately become start_ready=0, result_valid=0, busy=0, and all flags 0.
  - State goes to IDLE; start_ready rises in the first cycle after reset_n deasserts.
  - Any in-flight comparison is discarded.

## Timing
- Accept at edge N.
- busy=1 from after edge N until the edge that enters DONE.
- First differing bit at index k (early exit): result_valid is high after edge N+(WIDTH-k).
  - MSB differs: latency is 1 cycle.
  - Only bit 0 differs: latency is WIDTH cycles.
- Equal operands: latency is WIDTH cycles.
- Result handshake at edge M: start_ready=1 after edge M. The next accept can occur at edge M+1, so there is one idle cycle minimum between jobs.
- No combinational path from any input to any output; all outputs are registered.

## Configuration
- CMP_EARLY_EXIT_EN
  - Defined: SCAN terminates at the first differing bit, giving the latencies above.
  - Undefined:
    - SCAN always runs all WIDTH cycles, so latency is a constant WIDTH.
    - The first differing bit is captured in sticky registers; later bits cannot change it.
    - equal_to is set only if no bit differed.
    - The final flags are identical to the defined build.

## Test plan
- WIDTH=8, a=0xA5, b=0x25, result_ready=1 → greater_than=1.
  - Early-exit build: result_valid 1 cycle after accept.
  - Other build: 8 cycles after accept.
- a=0x3C, b=0x3D → less_than=1, result_valid 8 cycles after accept in both builds. Differing bit 0 is the last scanned.
- a=b=0x7E → equal_to=1 after 8 cycles.
  - Then a=0x00, b=0xFF → less_than=1.
  - Second accept occurs exactly 1 cycle after the first result handshake.
- Backpressure: hold result_ready=0 for 5 cycles after result_valid, with start_valid=1 and new operands.
  - Flags stay constant; start_ready stays 0; new operands are not latched.
  - Drop to IDLE 1 cycle after result_ready=1.
- a=0x80, b=0x7F, with reset_n pulsed low during SCAN at idx=4 (non-early-exit build).
  - All outputs go 0 immediately; start_ready=1 after release.
  - A re-issued a=0x01, b=0x02 returns less_than=1.
- WIDTH=1: a=1, b=0 → greater_than=1 after 1 cycle; a=b=1 → equal_to=1 after 1 cycle.
